// File: rtl/multi_pkg.sv
// Shared definitions for the fixed-latency sequential signed multiplier.
//   MULT_W   : default operand width
//   MULT_LAT : clocks from the accepting edge to the edge that raises valid
//   state_t  : control FSM encoding (IDLE, BUSY, DONE)
package multi_pkg;
  localparam int MULT_W   = 32;
  localparam int MULT_LAT = MULT_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/multi_if.sv
// Bundle of the multiplier's request/result signals.
//   mlier, mcand : signed operands, sampled on the accepting edge only
//   start        : level request, accepted whenever the unit is idle
//   prodt        : registered signed product, holds the last result
//   valid        : one-cycle pulse marking a new prodt
// Handshake: there is no ready signal. A request is accepted on any rising
// edge where start=1 and the unit is idle; start at any other time is ignored.
// valid rises exactly MULT_LAT edges after acceptance and lasts one cycle.
// master drives requests, slave is the multiplier side.
interface multi_if #(parameter int W = 32);
  logic [W-1:0]   mlier;
  logic [W-1:0]   mcand;
  logic           start;
  logic [2*W-1:0] prodt;
  logic           valid;

  modport master (output mlier, output mcand, output start,
                  input prodt, input valid);
  modport slave  (input mlier, input mcand, input start,
                  output prodt, output valid);
endinterface

// File: rtl/multi_booth_step.sv
// One radix-2 Booth iteration, purely combinational.
//   acc_i/acc_o   : W+1 bit signed accumulator (upper half of the product)
//   mq_i/mq_o     : W bit multiplier register (lower half of the product)
//   qm1_i/qm1_o   : bit shifted out of mq on the previous step (b[i-1])
//   mcand_i       : signed multiplicand
// The accumulator is one bit wider than the operands so that subtracting
// the most negative multiplicand cannot overflow.
module multi_booth_step #(
  parameter int W = 32
) (
  input  logic [W:0]   acc_i,
  input  logic [W-1:0] mq_i,
  input  logic         qm1_i,
  input  logic [W-1:0] mcand_i,
  output logic [W:0]   acc_o,
  output logic [W-1:0] mq_o,
  output logic         qm1_o
);
  logic [W:0] mcand_x;
  logic [W:0] sum;

  always_comb begin
    mcand_x = {mcand_i[W-1], mcand_i};
    sum     = acc_i;
    case ({mq_i[0], qm1_i})
      2'b01:   sum = acc_i + mcand_x;
      2'b10:   sum = acc_i - mcand_x;
      default: sum = acc_i;
    endcase
  end

  // Arithmetic right shift of the {sum, mq, qm1} chain by one.
  assign acc_o = {sum[W], sum[W:1]};
  assign mq_o  = {sum[0], mq_i[W-1:1]};
  assign qm1_o = mq_i[0];
endmodule

// File: rtl/fixed_latency_multi.sv
// Sequential signed W x W -> 2W multiplier with a single adder.
//   clock : rising-edge clock
//   reset : synchronous, active-low; clears result, valid and control
//   mlier : signed multiplier, captured on the accepting edge
//   mcand : signed multiplicand, captured on the accepting edge
//   prodt : registered signed product, held until the next completion
//   start : level request, accepted only in IDLE
//   valid : one-cycle pulse, W+1 edges after acceptance
// IDLE accepts, BUSY runs W Booth steps counted 0..W-1, DONE publishes the
// result for one cycle and returns to IDLE.
module fixed_latency_multi
  import multi_pkg::*;
#(
  parameter int W = MULT_W
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [W-1:0]   mlier,
  input  logic [W-1:0]   mcand,
  output logic [2*W-1:0] prodt,
  input  logic           start,
  output logic           valid
);
  localparam int CW = $clog2(W);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W:0]     acc_q, acc_d;
  logic [W-1:0]   mq_q, mq_d;
  logic           qm1_q, qm1_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [2*W-1:0] prodt_q, prodt_d;
  logic           valid_q, valid_d;

  logic [W:0]     acc_step;
  logic [W-1:0]   mq_step;
  logic           qm1_step;

  multi_booth_step #(.W(W)) u_step (
    .acc_i   (acc_q),
    .mq_i    (mq_q),
    .qm1_i   (qm1_q),
    .mcand_i (mcand_q),
    .acc_o   (acc_step),
    .mq_o    (mq_step),
    .qm1_o   (qm1_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    qm1_d   = qm1_q;
    mcand_d = mcand_q;
    prodt_d = prodt_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = mcand;
          mq_d    = mlier;
          qm1_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_step;
        mq_d  = mq_step;
        qm1_d = qm1_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // The true product fits in 2W bits, so the accumulator's extra
        // guard bit is only a sign copy and is dropped here.
        prodt_d = {acc_q[W-1:0], mq_q};
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      qm1_q   <= 1'b0;
      mcand_q <= '0;
      prodt_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      qm1_q   <= qm1_d;
      mcand_q <= mcand_d;
      prodt_q <= prodt_d;
      valid_q <= valid_d;
    end
  end

  assign prodt = prodt_q;
  assign valid = valid_q;
endmodule

// File: tb/tb_fixed_latency_multi.sv
// Self-checking bench for fixed_latency_multi: directed cases, a streaming
// run with start held high, BUSY interference, mid-run reset, and a random
// regression against a 64-bit signed golden product.
module tb_fixed_latency_multi;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [63:0] exp_q[$];

  multi_if #(.W(32)) bus ();

  fixed_latency_multi #(.W(32)) multi (
    .clock (clk),
    .reset (rst_n),
    .mlier (bus.mlier),
    .mcand (bus.mcand),
    .prodt (bus.prodt),
    .start (bus.start),
    .valid (bus.valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // golden model: plain 64-bit signed multiplication
  function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b);
    longint pa;
    longint pb;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    return 64'(pa * pb);
  endfunction

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver: one request from IDLE, wait (bounded) for valid, check latency,
  // product and the single-cycle pulse. Returns the observed product.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] obs);
    int lat;
    @(negedge clk);
    bus.mlier = a;
    bus.mcand = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    while (bus.valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_int({tag, "_latency"}, lat, 33);
    obs = bus.prodt;
    check64({tag, "_prodt"}, obs, golden(a, b));
    @(posedge clk);
    #1;
    check_int({tag, "_pulse"}, int'(bus.valid), 0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [5];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    logic [63:0] obs;
    logic [31:0] a;
    logic [31:0] b;
    int cyc;
    int last;
    int n;
    int vcount;
    int vlat;
    logic prev_v;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.mlier = '0;
    bus.mcand = '0;
    bus.start = 1'b1;   // reset must dominate start

    repeat (4) @(posedge clk);
    #1;
    check64("reset_prodt", bus.prodt, 64'd0);
    check_int("reset_valid", int'(bus.valid), 0);
    @(negedge clk);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_int("idle_no_valid", int'(bus.valid), 0);

    // directed cases
    run_op("d_3x5", 32'd3, 32'd5, obs);
    check64("d_3x5_const", obs, 64'd15);
    run_op("d_m7x6", -32'sd7, 32'd6, obs);
    check64("d_m7x6_const", obs, -64'sd42);
    run_op("d_minxmin", 32'h8000_0000, 32'h8000_0000, obs);
    check64("d_minxmin_const", obs, 64'd4611686018427387904);
    run_op("d_maxxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, obs);
    check64("d_maxxmax_const", obs, 64'd4611686014132420609);
    run_op("d_minx1", 32'h8000_0000, 32'd1, obs);
    check64("d_minx1_const", obs, -64'sd2147483648);
    run_op("d_0xany", 32'd0, 32'hDEAD_BEEF, obs);
    check64("d_0xany_const", obs, 64'd0);

    // streaming: start held high, new operands right after each valid
    @(negedge clk);
    a = $urandom;
    b = $urandom;
    bus.mlier = a;
    bus.mcand = b;
    bus.start = 1'b1;
    exp_q.push_back(golden(a, b));
    cyc    = 0;
    last   = 0;
    n      = 0;
    prev_v = 1'b0;
    while (n < 10 && cyc < 600) begin
      @(posedge clk);
      #1;
      cyc++;
      if (prev_v) check_int("stream_pulse", int'(bus.valid), 0);
      prev_v = bus.valid;
      if (bus.valid === 1'b1) begin
        check64("stream_prodt", bus.prodt, exp_q.pop_front());
        if (n == 0) check_int("stream_first", cyc, 34);
        else        check_int("stream_interval", cyc - last, 34);
        last = cyc;
        n++;
        if (n < 10) begin
          a = $urandom;
          b = $urandom;
          bus.mlier = a;
          bus.mcand = b;
          exp_q.push_back(golden(a, b));
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    check_int("stream_count", n, 10);
    @(posedge clk);
    #1;
    check_int("stream_end_pulse", int'(bus.valid), 0);

    // start and operand noise while BUSY must not disturb the result
    @(negedge clk);
    a = $urandom;
    b = $urandom;
    bus.mlier = a;
    bus.mcand = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    vcount = 0;
    vlat   = 0;
    obs    = '0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk);
      #1;
      if (bus.valid === 1'b1) begin
        vcount++;
        vlat = c;
        obs  = bus.prodt;
      end
      if (c <= 30) begin
        bus.mlier = $urandom;
        bus.mcand = $urandom;
        bus.start = 1'($urandom_range(0, 1));
      end else begin
        bus.start = 1'b0;
      end
    end
    check_int("busy_valid_count", vcount, 1);
    check_int("busy_latency", vlat, 33);
    check64("busy_prodt", obs, golden(a, b));

    // reset after 16 Booth steps aborts the operation
    @(negedge clk);
    bus.mlier = 32'd1234;
    bus.mcand = -32'sd5678;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check_int("pre_abort_no_valid", int'(bus.valid), 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_int("abort_valid", int'(bus.valid), 0);
    check64("abort_prodt", bus.prodt, 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.valid === 1'b1) vcount++;
    end
    check_int("abort_no_valid", vcount, 0);
    check64("abort_prodt_held", bus.prodt, 64'd0);
    run_op("after_abort", 32'd2, -32'sd3, obs);
    check64("after_abort_const", obs, -64'sd6);

    // random regression
    for (int i = 0; i < 1000; i++) begin
      a = pick_operand();
      b = pick_operand();
      run_op("rand", a, b, obs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
